// File: rtl/core_pkg.sv
// Shared definitions for the data-memory responder and its word array.
// Holds the default bus widths, the byte size, and the responder FSM state type.
package core_pkg;

    localparam int DEFAULT_DATA_WIDTH      = 32;
    localparam int DEFAULT_BYTE_DATA_WIDTH = 4;
    localparam int BYTE_SIZE               = 8;

    // Responder FSM states; RESP is the single cycle carrying data_valid.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } resp_state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// No reset: contents and read register power up undefined.
// Ports:
//   clk   - clock
//   en    - port enable; with we=0 the addressed word is loaded into rdata
//   we    - write select (only lanes with be=1 are written)
//   be    - byte-lane write mask
//   addr  - word index
//   wdata - write data
//   rdata - registered read data, held until the next read
module dmem_array
    import core_pkg::*;
#(
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int BYTE_DATA_WIDTH = DEFAULT_BYTE_DATA_WIDTH,
    parameter int DEPTH_LOG2      = 10
) (
    input  logic                       clk,
    input  logic                       en,
    input  logic                       we,
    input  logic [BYTE_DATA_WIDTH-1:0] be,
    input  logic [DEPTH_LOG2-1:0]      addr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    output logic [DATA_WIDTH-1:0]      rdata
);

    logic [DATA_WIDTH-1:0] mem_r [0:(1 << DEPTH_LOG2) - 1];
    logic [DATA_WIDTH-1:0] rdata_r;

    // Memory port: byte-lane writes or a full-word registered read.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < BYTE_DATA_WIDTH; i++) begin
                    if (be[i]) begin
                        mem_r[addr][i*BYTE_SIZE +: BYTE_SIZE] <= wdata[i*BYTE_SIZE +: BYTE_SIZE];
                    end
                end
            end else begin
                rdata_r <= mem_r[addr];
            end
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's data port (data_req/data_valid handshake).
// Accepts one request at a time, waits LATENCY cycles, then pulses data_valid.
// Ports:
//   clk         - clock
//   rst         - asynchronous active-low reset
//   data_req    - request level, held by the core until data_valid
//   data_we     - 1 = write, 0 = read (sampled at acceptance)
//   byte_enable - write lane mask
//   data_addr   - byte address, low two bits ignored
//   wdata       - write data (sampled at acceptance)
//   data_valid  - one-cycle response pulse
//   rdata       - read data, held until the next read response; 0 after reset
//   addr_err    - pulses with data_valid for out-of-range accesses
module dmem_responder
    import core_pkg::*;
#(
    parameter int                    DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int                    BYTE_DATA_WIDTH = DEFAULT_BYTE_DATA_WIDTH,
    parameter int                    DEPTH_LOG2      = 10,
    parameter int                    LATENCY         = 2,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR       = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       data_req,
    input  logic                       data_we,
    input  logic [BYTE_DATA_WIDTH-1:0] byte_enable,
    input  logic [DATA_WIDTH-1:0]      data_addr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    output logic                       data_valid,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic                       addr_err
);

    localparam logic [3:0] LAT_C    = 4'(LATENCY);
    localparam logic [3:0] LAT_M1_C = LAT_C - 4'd1;

    resp_state_e                state_r, state_next_s;
    logic [3:0]                 wait_cnt_r, wait_cnt_next_s;
    logic                       accept_s;

    logic                       we_r, err_r;
    logic [BYTE_DATA_WIDTH-1:0] be_r;
    logic [DEPTH_LOG2-1:0]      idx_r;
    logic [DATA_WIDTH-1:0]      wdata_r;

    logic [DATA_WIDTH-1:0]      offset_s, word_off_s;
    logic                       req_err_s;
    logic [DEPTH_LOG2-1:0]      req_idx_s;

    logic                       cur_we_s, cur_err_s;
    logic [DEPTH_LOG2-1:0]      cur_idx_s;
    logic                       enter_resp_s;

    logic                       ram_en_s, ram_we_s;
    logic [DEPTH_LOG2-1:0]      ram_addr_s;
    logic [DATA_WIDTH-1:0]      ram_q_s;

    logic                       data_valid_r, addr_err_r, rdata_vld_r;

    // Address decode; the subtraction wraps, so addresses below BASE_ADDR land out of range.
    always_comb begin
        offset_s   = data_addr - BASE_ADDR;
        word_off_s = offset_s >> 2'd2;
        req_err_s  = ((word_off_s >> DEPTH_LOG2) != {DATA_WIDTH{1'b0}});
        req_idx_s  = word_off_s[DEPTH_LOG2-1:0];
    end

    // Next-state and wait-counter logic.
    always_comb begin
        state_next_s    = state_r;
        wait_cnt_next_s = wait_cnt_r;
        accept_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (data_req) begin
                    accept_s = 1'b1;
                    if (LAT_C == 4'd0) begin
                        state_next_s    = ST_RESP;
                        wait_cnt_next_s = 4'd0;
                    end else begin
                        state_next_s    = ST_WAIT;
                        wait_cnt_next_s = LAT_M1_C;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == 4'd0) begin
                    state_next_s = ST_RESP;
                end else begin
                    wait_cnt_next_s = wait_cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s    = ST_IDLE;
                wait_cnt_next_s = 4'd0;
            end
        endcase
    end

    // Attributes of the transaction in flight: with LATENCY=0 the response is
    // entered on the acceptance edge itself, so the live inputs are used in IDLE.
    always_comb begin
        cur_we_s  = we_r;
        cur_err_s = err_r;
        cur_idx_s = idx_r;
        if (state_r == ST_IDLE) begin
            cur_we_s  = data_we;
            cur_err_s = req_err_s;
            cur_idx_s = req_idx_s;
        end else begin
            cur_we_s  = we_r;
            cur_err_s = err_r;
            cur_idx_s = idx_r;
        end
    end

    // RAM port control: the read is launched on the edge entering RESP so the word
    // is ready during RESP; the write lands on the edge that ends RESP.
    always_comb begin
        enter_resp_s = (state_next_s == ST_RESP);
        ram_we_s     = (state_r == ST_RESP);
        ram_en_s     = 1'b0;
        ram_addr_s   = cur_idx_s;
        if (state_r == ST_RESP) begin
            ram_en_s   = we_r & ~err_r;
            ram_addr_s = idx_r;
        end else begin
            ram_en_s   = enter_resp_s & ~cur_we_s & ~cur_err_s;
            ram_addr_s = cur_idx_s;
        end
    end

    // FSM state and wait counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 4'd0;
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_cnt_next_s;
        end
    end

    // Capture of the accepted request; later changes on the inputs are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_r    <= 1'b0;
            err_r   <= 1'b0;
            be_r    <= {BYTE_DATA_WIDTH{1'b0}};
            idx_r   <= {DEPTH_LOG2{1'b0}};
            wdata_r <= {DATA_WIDTH{1'b0}};
        end else if (accept_s) begin
            we_r    <= data_we;
            err_r   <= req_err_s;
            be_r    <= byte_enable;
            idx_r   <= req_idx_s;
            wdata_r <= wdata;
        end
    end

    // Response flags; rdata_vld_r selects the RAM word, otherwise rdata reads as zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_valid_r <= 1'b0;
            addr_err_r   <= 1'b0;
            rdata_vld_r  <= 1'b0;
        end else begin
            data_valid_r <= enter_resp_s;
            addr_err_r   <= enter_resp_s & cur_err_s;
            if (enter_resp_s && !cur_we_s) begin
                rdata_vld_r <= ~cur_err_s;
            end
        end
    end

    dmem_array #(
        .DATA_WIDTH      (DATA_WIDTH),
        .BYTE_DATA_WIDTH (BYTE_DATA_WIDTH),
        .DEPTH_LOG2      (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .en    (ram_en_s),
        .we    (ram_we_s),
        .be    (be_r),
        .addr  (ram_addr_s),
        .wdata (wdata_r),
        .rdata (ram_q_s)
    );

    assign data_valid = data_valid_r;
    assign addr_err   = addr_err_r;
    assign rdata      = ram_q_s & {DATA_WIDTH{rdata_vld_r}};

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 uses LATENCY=2, instance 1 uses LATENCY=0.
// A cycle-numbered transaction model predicts outputs every cycle; directed
// transactions also check hand-computed literal results.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       req, we;
    logic [1:0][3:0]  be;
    logic [1:0][31:0] addr, wd;
    logic [1:0]       dv, aerr;
    logic [1:0][31:0] rd;

    int checks = 0;
    int errors = 0;

    dmem_responder #(.DATA_WIDTH(32), .BYTE_DATA_WIDTH(4), .DEPTH_LOG2(10),
                     .LATENCY(2), .BASE_ADDR(32'h0)) u_dut_l2 (
        .clk(clk), .rst(rst), .data_req(req[0]), .data_we(we[0]),
        .byte_enable(be[0]), .data_addr(addr[0]), .wdata(wd[0]),
        .data_valid(dv[0]), .rdata(rd[0]), .addr_err(aerr[0]));

    dmem_responder #(.DATA_WIDTH(32), .BYTE_DATA_WIDTH(4), .DEPTH_LOG2(10),
                     .LATENCY(0), .BASE_ADDR(32'h0)) u_dut_l0 (
        .clk(clk), .rst(rst), .data_req(req[1]), .data_we(we[1]),
        .byte_enable(be[1]), .data_addr(addr[1]), .wdata(wd[1]),
        .data_valid(dv[1]), .rdata(rd[1]), .addr_err(aerr[1]));

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mem [2][1024];
    int          cyc = 0;
    bit          busy [2];
    int          resp_c [2];
    bit          m_we [2], m_err [2];
    logic [3:0]  m_be [2];
    int          m_idx [2];
    logic [31:0] m_wd [2];
    logic [31:0] exp_rd [2];

    initial begin
        logic [31:0] off;
        bit          ev;
        for (int d = 0; d < 2; d++) begin
            busy[d] = 1'b0; exp_rd[d] = 32'h0; resp_c[d] = 0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (!rst) begin
                    busy[d] = 1'b0; exp_rd[d] = 32'h0;
                end else begin
                    if (busy[d] && resp_c[d] == cyc - 1) begin
                        if (m_we[d] && !m_err[d])
                            for (int i = 0; i < 4; i++)
                                if (m_be[d][i]) mem[d][m_idx[d]][8*i +: 8] = m_wd[d][8*i +: 8];
                        busy[d] = 1'b0;
                    end else if (!busy[d] && req[d]) begin
                        off       = addr[d] - 32'h0;
                        busy[d]   = 1'b1;
                        resp_c[d] = cyc + lat_of(d);
                        m_we[d]   = we[d];
                        m_be[d]   = be[d];
                        m_wd[d]   = wd[d];
                        m_err[d]  = (off >= 32'd4096);
                        m_idx[d]  = m_err[d] ? 0 : int'(off / 32'd4);
                    end
                    if (busy[d] && resp_c[d] == cyc && !m_we[d])
                        exp_rd[d] = m_err[d] ? 32'h0 : mem[d][m_idx[d]];
                end
            end
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst) begin
                    busy[d] = 1'b0; exp_rd[d] = 32'h0;
                end
                ev = busy[d] && (resp_c[d] == cyc);
                chk($sformatf("model dut%0d data_valid cyc%0d", d, cyc), {31'b0, dv[d]}, {31'b0, ev});
                chk($sformatf("model dut%0d addr_err cyc%0d", d, cyc), {31'b0, aerr[d]}, {31'b0, ev & m_err[d]});
                chk($sformatf("model dut%0d rdata cyc%0d", d, cyc), rd[d], exp_rd[d]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    // One request: returns response data, error flag and the number of cycles
    // from the acceptance edge to the cycle carrying data_valid.
    task automatic xact(input int d, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] dat,
                        output logic [31:0] r, output logic e, output int lat);
        int  n;
        bit  found;
        @(posedge clk); #1;
        req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wd[d] = dat;
        n = 0; found = 1'b0;
        while (!found && n < 40) begin
            @(negedge clk);
            n++;
            if (dv[d]) found = 1'b1;
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL timeout dut%0d addr %h: got no data_valid expected one", d, a);
        end
        r = rd[d]; e = aerr[d]; lat = n - 1;
        @(posedge clk); #1;
        req[d] = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        int          lat, k, pulses;
        rst = 1'b0; req = 2'b00; we = 2'b00; be = '0; addr = '0; wd = '0;
        repeat (2) @(negedge clk);
        chk("reset data_valid", {30'b0, dv}, 32'h0);
        chk("reset addr_err", {30'b0, aerr}, 32'h0);
        chk("reset rdata", rd[0], 32'h0);
        @(posedge clk); #1; rst = 1'b1;

        // LATENCY=2: full write then read back
        xact(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, r, e, lat);
        chk("l2 write latency", lat, 32'd3);
        chk("l2 write addr_err", {31'b0, e}, 32'h0);
        xact(0, 1'b0, 4'hF, 32'h10, 32'h0, r, e, lat);
        chk("l2 read 0x10", r, 32'hDEADBEEF);

        // partial write
        xact(0, 1'b1, 4'hF, 32'h20, 32'h11223344, r, e, lat);
        xact(0, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, r, e, lat);
        xact(0, 1'b0, 4'hF, 32'h20, 32'h0, r, e, lat);
        chk("partial write 0x20", r, 32'h11BB33DD);

        // back-to-back reads with request inputs disturbed during WAIT
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b0; be[0] = 4'hF; addr[0] = 32'h10; wd[0] = 32'h0;
        @(posedge clk); #1;
        addr[0] = 32'h3FC; we[0] = 1'b1; wd[0] = 32'h0BAD0BAD;
        k = 0;
        do begin @(negedge clk); k++; end while (!dv[0] && k < 20);
        chk("b2b first data", rd[0], 32'hDEADBEEF);
        addr[0] = 32'h20; we[0] = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!dv[0] && k < 20);
        chk("b2b pulse spacing", k, 32'd4);
        chk("b2b second data", rd[0], 32'h11BB33DD);
        @(posedge clk); #1; req[0] = 1'b0;

        // out of range
        xact(0, 1'b1, 4'hF, 32'h0, 32'h01020304, r, e, lat);
        xact(0, 1'b0, 4'hF, 32'h0000_1000, 32'h0, r, e, lat);
        chk("oor read rdata", r, 32'h0);
        chk("oor read addr_err", {31'b0, e}, 32'h1);
        chk("oor read latency", lat, 32'd3);
        xact(0, 1'b1, 4'hF, 32'h0000_1000, 32'hFFFFFFFF, r, e, lat);
        chk("oor write addr_err", {31'b0, e}, 32'h1);
        xact(0, 1'b0, 4'hF, 32'h0, 32'h0, r, e, lat);
        chk("word0 after oor write", r, 32'h01020304);
        xact(0, 1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0, r, e, lat);
        chk("wrapped address addr_err", {31'b0, e}, 32'h1);
        xact(0, 1'b0, 4'hF, 32'h13, 32'h0, r, e, lat);
        chk("misaligned read 0x13", r, 32'hDEADBEEF);
        chk("misaligned addr_err", {31'b0, e}, 32'h0);

        // LATENCY=0 instance
        xact(1, 1'b1, 4'hF, 32'h10, 32'hCAFEF00D, r, e, lat);
        chk("l0 write latency", lat, 32'd1);
        xact(1, 1'b0, 4'hF, 32'h10, 32'h0, r, e, lat);
        chk("l0 read latency", lat, 32'd1);
        chk("l0 read data", r, 32'hCAFEF00D);
        xact(1, 1'b1, 4'b0000, 32'h10, 32'h12345678, r, e, lat);
        chk("l0 be0 addr_err", {31'b0, e}, 32'h0);
        xact(1, 1'b0, 4'hF, 32'h10, 32'h0, r, e, lat);
        chk("l0 data after be0 write", r, 32'hCAFEF00D);

        // reset during WAIT discards the pending write
        xact(0, 1'b1, 4'hF, 32'h8, 32'h11111111, r, e, lat);
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'h8; wd[0] = 32'h55;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid reset data_valid", {31'b0, dv[0]}, 32'h0);
        chk("mid reset addr_err", {31'b0, aerr[0]}, 32'h0);
        @(posedge clk); #1; req[0] = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        pulses = 0;
        repeat (6) begin @(negedge clk); if (dv[0]) pulses++; end
        chk("no pulse after reset", pulses, 32'd0);
        xact(0, 1'b0, 4'hF, 32'h8, 32'h0, r, e, lat);
        chk("old value after reset", r, 32'h11111111);
        chk("post reset latency", lat, 32'd3);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
